fib_port_arbiter: RTL and testbench

FIB_PORT_ARBITER -- requirements
Module: fib_port_arbiter

---
 rtl/fib_port_arbiter_pkg.sv | 18 +
 rtl/fib_rr_arbiter.sv | 26 ++
 rtl/fib_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_fib_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_port_arbiter_pkg.sv
// rtl/fib_port_arbiter_pkg.sv - shared header codes, packet lengths and FSM encoding
package fib_port_arbiter_pkg;
    localparam logic [3:0] HDR_INTEREST     = 4'h7;
    localparam logic [3:0] HDR_DATA         = 4'h3;
    localparam int         INTEREST_LEN_DEF = 9;
    localparam int         DATA_LEN_DEF     = 41;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BODY   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic hdr_known(input logic [3:0] nib);
        return (nib == HDR_INTEREST) || (nib == HDR_DATA);
    endfunction
endpackage

// File: rtl/fib_rr_arbiter.sv
// rtl/fib_rr_arbiter.sv - two-way round-robin pick; pointer remembers the last winner
module fib_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic pick,
    output logic any
);
    logic last_b;

    // Contention goes to whoever did not win last time; a lone request always wins.
    always_comb begin
        any  = req_a | req_b;
        pick = (req_a && req_b) ? ~last_b : req_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (take && any) begin
            last_b <= pick;
        end
    end
endmodule

// File: rtl/fib_port_arbiter.sv
// rtl/fib_port_arbiter.sv - grants the FIB byte stream to SPI ingress or PIT egress, one packet at a time
module fib_port_arbiter
    import fib_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int INTEREST_LEN   = INTEREST_LEN_DEF,
    parameter int DATA_LEN       = DATA_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_req,
    input  logic       spi_byte_valid,
    input  logic [7:0] spi_byte,
    input  logic       pit_req,
    input  logic       pit_byte_valid,
    input  logic [7:0] pit_byte,
    output logic       spi_gnt,
    output logic       pit_gnt,
    output logic [7:0] fib_byte,
    output logic       fib_byte_valid,
    output logic       fib_src,
    output logic       fib_sop,
    output logic       fib_eop,
    output logic       fib_abort,
    output logic       err_bad_type,
    output logic       err_timeout
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state, state_n;
    logic           src_n, is_data, is_data_n;
    logic [5:0]     cnt, cnt_n, len_cur;
    logic [IW-1:0]  idle, idle_n;
    logic [7:0]     byte_n;
    logic           valid_n, sop_n, eop_n, abort_n, bad_n, tmo_n;
    logic           pick, any_req, busy;
    logic           g_valid;
    logic [7:0]     g_byte;

    fib_rr_arbiter u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_a (spi_req),
        .req_b (pit_req),
        .take  (state == ST_IDLE),
        .pick  (pick),
        .any   (any_req)
    );

    assign busy    = (state == ST_HEADER) || (state == ST_BODY);
    assign spi_gnt = busy && !fib_src;
    assign pit_gnt = busy && fib_src;
    assign g_valid = fib_src ? pit_byte_valid : spi_byte_valid;
    assign g_byte  = fib_src ? pit_byte : spi_byte;
    assign len_cur = is_data ? DATA_LEN[5:0] : INTEREST_LEN[5:0];

    always_comb begin
        state_n   = state;
        src_n     = fib_src;
        is_data_n = is_data;
        cnt_n     = cnt;
        idle_n    = idle;
        byte_n    = 8'h00;
        valid_n   = 1'b0;
        sop_n     = 1'b0;
        eop_n     = 1'b0;
        abort_n   = 1'b0;
        bad_n     = 1'b0;
        tmo_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_n = ST_HEADER;
                    src_n   = pick;
                    cnt_n   = '0;
                    idle_n  = '0;
                end
            end
            ST_HEADER, ST_BODY: begin
                // A granted byte always wins over an idle expiry in the same cycle.
                if (g_valid) begin
                    idle_n = '0;
                    if (state == ST_HEADER && !hdr_known(g_byte[7:4])) begin
                        bad_n   = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        byte_n  = g_byte;
                        valid_n = 1'b1;
                        if (state == ST_HEADER) begin
                            sop_n     = 1'b1;
                            cnt_n     = 6'd1;
                            is_data_n = (g_byte[7:4] == HDR_DATA);
                            state_n   = ST_BODY;
                        end else begin
                            cnt_n = cnt + 6'd1;
                            if (cnt + 6'd1 == len_cur) begin
                                eop_n   = 1'b1;
                                state_n = ST_DONE;
                            end
                        end
                    end
                end else if (idle == IW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_n   = 1'b1;
                    abort_n = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    idle_n = idle + IW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                idle_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            fib_src        <= 1'b0;
            is_data        <= 1'b0;
            cnt            <= '0;
            idle           <= '0;
            fib_byte       <= 8'h00;
            fib_byte_valid <= 1'b0;
            fib_sop        <= 1'b0;
            fib_eop        <= 1'b0;
            fib_abort      <= 1'b0;
            err_bad_type   <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state          <= state_n;
            fib_src        <= src_n;
            is_data        <= is_data_n;
            cnt            <= cnt_n;
            idle           <= idle_n;
            fib_byte       <= byte_n;
            fib_byte_valid <= valid_n;
            fib_sop        <= sop_n;
            fib_eop        <= eop_n;
            fib_abort      <= abort_n;
            err_bad_type   <= bad_n;
            err_timeout    <= tmo_n;
        end
    end
endmodule

// File: tb/tb_fib_port_arbiter.sv
// tb/tb_fib_port_arbiter.sv - randomized self-checking bench for fib_port_arbiter
module tb_fib_port_arbiter;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_req, spi_byte_valid, pit_req, pit_byte_valid;
    logic [7:0] spi_byte, pit_byte, fib_byte;
    logic       spi_gnt, pit_gnt, fib_byte_valid, fib_src, fib_sop, fib_eop;
    logic       fib_abort, err_bad_type, err_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int force_idx = -1;
    int force_gap = 0;

    bit         obs_v [int];
    bit         obs_sop [int];
    bit         obs_eop [int];
    bit         obs_abort [int];
    bit         obs_bad [int];
    bit         obs_tmo [int];
    bit         obs_sg [int];
    bit         obs_pg [int];
    bit         obs_src [int];
    logic [7:0] obs_b [int];
    int         smp[$];
    logic [7:0] pkt[$];

    always #5 clk = ~clk;

    fib_port_arbiter #(.TIMEOUT_CYCLES(TMO), .INTEREST_LEN(9), .DATA_LEN(41)) dut (
        .clk(clk), .rst(rst),
        .spi_req(spi_req), .spi_byte_valid(spi_byte_valid), .spi_byte(spi_byte),
        .pit_req(pit_req), .pit_byte_valid(pit_byte_valid), .pit_byte(pit_byte),
        .spi_gnt(spi_gnt), .pit_gnt(pit_gnt), .fib_byte(fib_byte), .fib_byte_valid(fib_byte_valid),
        .fib_src(fib_src), .fib_sop(fib_sop), .fib_eop(fib_eop), .fib_abort(fib_abort),
        .err_bad_type(err_bad_type), .err_timeout(err_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        obs_v[cyc] = fib_byte_valid; obs_b[cyc] = fib_byte; obs_sop[cyc] = fib_sop;
        obs_eop[cyc] = fib_eop; obs_abort[cyc] = fib_abort; obs_bad[cyc] = err_bad_type;
        obs_tmo[cyc] = err_timeout; obs_sg[cyc] = spi_gnt; obs_pg[cyc] = pit_gnt; obs_src[cyc] = fib_src;
    endtask

    task automatic quiet();
        spi_byte_valid = 1'b0; spi_byte = 8'h00;
        pit_byte_valid = 1'b0; pit_byte = 8'h00;
    endtask

    task automatic set_req(input bit port, input logic v);
        if (port) pit_req = v;
        else      spi_req = v;
    endtask

    // Drives one port and puts random traffic on the other, which must never be observed.
    task automatic drive(input bit port, input logic v, input logic [7:0] b);
        logic       nv = 1'($urandom_range(0, 1));
        logic [7:0] nb = 8'($urandom);
        if (port) begin
            pit_byte_valid = v; pit_byte = b; spi_byte_valid = nv; spi_byte = nb;
        end else begin
            spi_byte_valid = v; spi_byte = b; pit_byte_valid = nv; pit_byte = nb;
        end
    endtask

    task automatic send_bytes(input bit port, input int max_gap);
        int budget = 0;
        smp.delete();
        while (!(port ? pit_gnt : spi_gnt) && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (budget >= 20) begin
            failures++;
            $display("FAIL grant_wait port=%0d got no grant in %0d cycles, required grant", port, budget);
        end
        foreach (pkt[i]) begin
            int gap = (i == force_idx) ? force_gap : $urandom_range(0, max_gap);
            repeat (gap) begin
                drive(port, 1'b0, 8'h00);
                tick();
            end
            drive(port, 1'b1, pkt[i]);
            smp.push_back(cyc + 1);
            tick();
        end
        quiet();
    endtask

    task automatic make_interest();
        pkt.delete();
        pkt.push_back({4'h7, 4'($urandom)});
        repeat (8) pkt.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_req = 1'b1; pit_req = 1'b1;
        spi_byte_valid = 1'b1; spi_byte = 8'h7F; pit_byte_valid = 1'b1; pit_byte = 8'h3C;
        repeat (2) begin
            tick();
            checks++;
            if ({spi_gnt, pit_gnt, fib_byte_valid, fib_byte, fib_src, fib_sop, fib_eop,
                 fib_abort, err_bad_type, err_timeout} !== 17'h0) begin
                failures++;
                $display("FAIL reset_outputs got gnt=%0b%0b v=%0b b=%02h src=%0b, required all zero",
                         spi_gnt, pit_gnt, fib_byte_valid, fib_byte, fib_src);
            end
        end
        rst = 1'b0; spi_req = 1'b0; pit_req = 1'b0; quiet();
        tick();
        checks++;
        if ({spi_gnt, pit_gnt, fib_byte_valid, fib_src} !== 4'h0) begin
            failures++;
            $display("FAIL reset_release got gnt=%0b%0b v=%0b src=%0b, required zero", spi_gnt, pit_gnt, fib_byte_valid, fib_src);
        end
    endtask

    // kind: 0 interest, 1 data, 2 unknown header, 3 fixed interest vector
    task automatic test_packet(input bit port, input int kind, input int max_gap);
        logic [7:0] vec [9] = '{8'h70, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [3:0] nib;
        int r, len, n, last, vcnt, ecnt, acnt, bcnt, gbad;
        case (kind)
            0, 3:    begin nib = 4'h7; len = 9; end
            1:       begin nib = 4'h3; len = 41; end
            default: begin
                do nib = 4'($urandom); while (nib == 4'h7 || nib == 4'h3);
                len = 0;
            end
        endcase
        n = (len == 0) ? 1 : len + 2;
        pkt.delete();
        pkt.push_back({nib, 4'($urandom)});
        for (int i = 1; i < n; i++) pkt.push_back(8'($urandom));
        if (kind == 3) for (int i = 0; i < 9; i++) pkt[i] = vec[i];

        set_req(port, 1'b1); r = cyc + 1; tick(); set_req(port, 1'b0);
        send_bytes(port, max_gap);
        quiet();
        repeat (3) tick();
        last = (len == 0) ? smp[0] : smp[len-1];

        checks++;
        if ((port ? obs_pg[r] : obs_sg[r]) !== 1'b1 || (port ? obs_sg[r] : obs_pg[r]) !== 1'b0 || obs_src[r] !== port) begin
            failures++;
            $display("FAIL grant_start port=%0d got sg=%0b pg=%0b src=%0b, required grant to port %0d",
                     port, obs_sg[r], obs_pg[r], obs_src[r], port);
        end
        for (int i = 0; i < len; i++) begin
            int c = smp[i];
            checks++;
            if (!obs_v[c] || obs_b[c] !== pkt[i] || obs_sop[c] !== (i == 0) || obs_eop[c] !== (i == len - 1)) begin
                failures++;
                $display("FAIL fwd_byte%0d port=%0d got v=%0b b=%02h sop=%0b eop=%0b, required v=1 b=%02h sop=%0b eop=%0b",
                         i, port, obs_v[c], obs_b[c], obs_sop[c], obs_eop[c], pkt[i], i == 0, i == len - 1);
            end
        end
        vcnt = 0; ecnt = 0; acnt = 0; bcnt = 0; gbad = 0;
        for (int c = r; c <= cyc; c++) begin
            vcnt += int'(obs_v[c]); ecnt += int'(obs_eop[c]);
            acnt += int'(obs_abort[c] | obs_tmo[c]); bcnt += int'(obs_bad[c]);
            if (c < last) begin
                if ((port ? obs_pg[c] : obs_sg[c]) !== 1'b1 || (port ? obs_sg[c] : obs_pg[c]) !== 1'b0 || obs_src[c] !== port)
                    gbad++;
            end else if (obs_sg[c] || obs_pg[c]) begin
                gbad++;
            end
        end
        checks++;
        if (vcnt != len || ecnt != ((len > 0) ? 1 : 0) || acnt != 0) begin
            failures++;
            $display("FAIL pkt_counts kind=%0d got valid=%0d eop=%0d abort=%0d, required valid=%0d eop=%0d abort=0",
                     kind, vcnt, ecnt, acnt, len, (len > 0) ? 1 : 0);
        end
        checks++;
        if (bcnt != ((len == 0) ? 1 : 0) || (len == 0 && !obs_bad[smp[0]])) begin
            failures++;
            $display("FAIL bad_type kind=%0d got pulses=%0d, required %0d", kind, bcnt, (len == 0) ? 1 : 0);
        end
        checks++;
        if (gbad != 0) begin
            failures++;
            $display("FAIL grant_hold kind=%0d port=%0d got %0d wrong grant cycles, required 0", kind, port, gbad);
        end
    endtask

    task automatic test_contention();
        int r, spi_last, pit_last, budget;
        rst = 1'b1; quiet(); tick(); rst = 1'b0;
        spi_req = 1'b1; pit_req = 1'b1; r = cyc + 1; tick();
        checks++;
        if (obs_sg[r] !== 1'b1 || obs_pg[r] !== 1'b0) begin
            failures++;
            $display("FAIL rr_first got sg=%0b pg=%0b, required sg=1 pg=0", obs_sg[r], obs_pg[r]);
        end
        make_interest(); send_bytes(1'b0, 1); spi_last = smp[8];
        make_interest(); send_bytes(1'b1, 1); pit_last = smp[8];
        checks++;
        if (obs_pg[spi_last+2] !== 1'b1 || obs_pg[spi_last+1] !== 1'b0 || obs_sg[spi_last+1] !== 1'b0 ||
            obs_sg[spi_last+2] !== 1'b0 || obs_src[spi_last+2] !== 1'b1) begin
            failures++;
            $display("FAIL rr_second got pg=%0b%0b sg=%0b%0b src=%0b, required pg=01 sg=00 src=1",
                     obs_pg[spi_last+1], obs_pg[spi_last+2], obs_sg[spi_last+1], obs_sg[spi_last+2], obs_src[spi_last+2]);
        end
        checks++;
        if (!obs_eop[pit_last] || obs_b[pit_last] !== pkt[8] || obs_src[pit_last] !== 1'b1) begin
            failures++;
            $display("FAIL rr_pit_eop got eop=%0b b=%02h src=%0b, required eop=1 b=%02h src=1",
                     obs_eop[pit_last], obs_b[pit_last], obs_src[pit_last], pkt[8]);
        end
        budget = 0;
        while (!spi_gnt && budget < 10) begin
            tick();
            budget++;
        end
        spi_req = 1'b0; pit_req = 1'b0;
        checks++;
        if (obs_sg[pit_last+2] !== 1'b1 || obs_pg[pit_last+2] !== 1'b0 || obs_sg[pit_last+1] !== 1'b0) begin
            failures++;
            $display("FAIL rr_third got sg=%0b%0b pg=%0b, required sg=01 pg=0",
                     obs_sg[pit_last+1], obs_sg[pit_last+2], obs_pg[pit_last+2]);
        end
        make_interest(); send_bytes(1'b0, 1); quiet(); repeat (3) tick();
        checks++;
        if (!obs_eop[smp[8]] || obs_src[smp[8]] !== 1'b0 || obs_sg[smp[8]+1] || obs_pg[smp[8]+1]) begin
            failures++;
            $display("FAIL req_drop got eop=%0b src=%0b, required eop=1 src=0 then idle", obs_eop[smp[8]], obs_src[smp[8]]);
        end
    endtask

    task automatic test_timeout();
        int r, d, hit, budget, vcnt, ecnt, tcnt;
        pkt.delete(); pkt.push_back(8'h7A);
        repeat (3) pkt.push_back(8'($urandom));
        set_req(1'b1, 1'b1); r = cyc + 1; tick(); set_req(1'b1, 1'b0);
        send_bytes(1'b1, 2); d = smp[3];
        hit = -1; budget = 0;
        while (hit < 0 && budget < 3 * TMO) begin
            drive(1'b1, 1'b0, 8'h00);
            tick();
            budget++;
            if (err_timeout) hit = cyc;
        end
        quiet(); repeat (2) tick();
        checks++;
        if (hit != d + TMO) begin
            failures++;
            $display("FAIL timeout_time got cycle offset %0d, required %0d", hit - d, TMO);
        end
        checks++;
        if (hit < 0 || !obs_abort[hit] || obs_pg[hit] || !obs_pg[hit-1]) begin
            failures++;
            $display("FAIL timeout_abort got hit=%0d, required abort with err_timeout and grant drop", hit);
        end
        vcnt = 0; ecnt = 0; tcnt = 0;
        for (int c = r; c <= cyc; c++) begin
            vcnt += int'(obs_v[c]); ecnt += int'(obs_eop[c]); tcnt += int'(obs_tmo[c]);
        end
        checks++;
        if (vcnt != 4 || ecnt != 0 || tcnt != 1) begin
            failures++;
            $display("FAIL timeout_counts got valid=%0d eop=%0d tmo=%0d, required 4 0 1", vcnt, ecnt, tcnt);
        end
    endtask

    task automatic test_long_gap();
        int tcnt = 0;
        make_interest();
        force_idx = 5; force_gap = TMO - 2;
        spi_req = 1'b1; tick(); spi_req = 1'b0;
        send_bytes(1'b0, 0);
        force_idx = -1;
        repeat (2) tick();
        for (int c = smp[0]; c <= cyc; c++) tcnt += int'(obs_tmo[c] | obs_abort[c]);
        checks++;
        if (tcnt != 0 || !obs_eop[smp[8]] || obs_b[smp[8]] !== pkt[8]) begin
            failures++;
            $display("FAIL long_gap got tmo=%0d eop=%0b, required tmo=0 eop=1", tcnt, obs_eop[smp[8]]);
        end
    endtask

    task automatic test_reset_mid();
        int r, vcnt = 0, ecnt = 0, acnt = 0;
        pkt.delete(); pkt.push_back(8'h3E);
        repeat (19) pkt.push_back(8'($urandom));
        pit_req = 1'b1; r = cyc + 1; tick(); pit_req = 1'b0;
        send_bytes(1'b1, 1);
        rst = 1'b1; drive(1'b1, 1'b1, 8'hAA); tick();
        checks++;
        if ({spi_gnt, pit_gnt, fib_byte_valid, fib_byte, fib_src, fib_sop, fib_eop,
             fib_abort, err_bad_type, err_timeout} !== 17'h0) begin
            failures++;
            $display("FAIL reset_mid got gnt=%0b%0b v=%0b b=%02h src=%0b, required all zero",
                     spi_gnt, pit_gnt, fib_byte_valid, fib_byte, fib_src);
        end
        rst = 1'b0; quiet(); tick();
        for (int c = r; c <= cyc; c++) begin
            vcnt += int'(obs_v[c]); ecnt += int'(obs_eop[c]); acnt += int'(obs_abort[c] | obs_tmo[c]);
        end
        checks++;
        if (vcnt != 20 || ecnt != 0 || acnt != 0) begin
            failures++;
            $display("FAIL reset_mid_counts got valid=%0d eop=%0d abort=%0d, required 20 0 0", vcnt, ecnt, acnt);
        end
        test_packet(1'b0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; spi_req = 1'b0; pit_req = 1'b0; quiet();
        test_reset();
        test_packet(1'b0, 3, 0);
        test_packet(1'b1, 1, 0);
        test_contention();
        test_packet(1'b0, 2, 1);
        test_timeout();
        test_long_gap();
        test_reset_mid();
        for (int k = 0; k < 8; k++)
            test_packet(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
